id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register, directly downstream of the instruction controller.
- Captures the decoded control bundle together with operands, PC values, immediate and register indices at the end of ID, and presents them to EX one cycle later.
- Provides the stall (hold) and flush (bubble insert) controls the hazard unit needs for load-use stalls and taken branches/jumps.

Parameters:
- XLEN, 64, datapath width for operands, PC and immediate.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall_e  in  1  hold current EX contents.
- flush_e  in  1  replace next EX contents with a bubble.
- valid_d  in  1  ID holds a real instruction.
- reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, wd3_src_d  in  1 each  control bits from the controller.
- result_src_d  in  2  write-back select.
- alu_control_d  in  4  ALU operation code.
- funct3_d  in  3  branch condition / load-store size.
- rd1_d, rd2_d  in  XLEN  register-file read data.
- pc_d, pc_plus4_d, imm_ext_d  in  XLEN  PC, PC+4, extended immediate.
- rs1_d, rs2_d, rd_d  in  REG_AW  source and destination indices, used for forwarding.
- valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, wd3_src_e  out  1 each  registered copies of the above.
- result_src_e  out  2  registered copy.
- alu_control_e  out  4  registered copy.
- funct3_e  out  3  registered copy.
- rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e  out  XLEN  registered copies.
- rs1_e, rs2_e, rd_e  out  REG_AW  registered copies.

Behaviour:
- Latency: one cycle. Every output is a flop; there are no combinational input-to-output paths.
- Priority at each rising clk edge, highest first:
  1. rst_n=0: all outputs go to 0.
  2. flush_e=1: all outputs go to 0. This is a bubble: valid_e=0, reg_write_e=0, mem_write_e=0, jump_e=0, branch_e=0.
  3. stall_e=1: all outputs hold their previous values.
  4. Otherwise: every *_e output loads its *_d input, and valid_e loads valid_d.
- flush_e and stall_e together: the flush wins. Bubble insertion during a load-use stall must never leave a stale instruction in EX.
- Reset asserted mid-stall or mid-flush: reset wins. State is zero on the following cycle regardless of the other inputs.
- A bubble is a legal NOP downstream:
  - alu_control_e=0 (ADD), result_src_e=00, rd_e=0, so there are no side effects.
  - Bubbles also zero the data fields, which keeps waveforms deterministic and the flops simple.
- valid_d=0 with no stall and no flush: control and data still load verbatim. valid_e=0 marks the slot as invalid.
- The block performs no gating of control bits by valid. The controller already emits safe no-op values for unsupported opcodes.
- Consecutive stalls: the outputs hold indefinitely. There is no internal counter and no timeout.
- Stall followed by a flush: the cycle after flush_e is a bubble. The stalled instruction is discarded by design, because the hazard unit re-issues from IF/ID.
- alu_control_e encoding, passed through unchanged: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT, 0101 XOR, 1000 SH1ADD, 1001 SH2ADD, 1010 SH3ADD, 1011 ADD.UW.
- No reset value is X. A bench check for X on any output after the first reset edge must pass.

Decomposition:
- Shared package core_pkg holds:
  - The ALU control localparams (ALU_ADD … ALU_ADD_UW).
  - The result_src encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_IMM=11.
  - Imm-source encodings I=000, S=001, B=010, U=011, J=100.
  - A packed struct ctrl_bundle_t grouping the control bits, so that the later ex_mem stage reuses it.
- One natural sub-module: pipe_reg_en_clr. It is a parameterised-WIDTH flop with a synchronous active-low reset, synchronous clear, and an enable (en = ~stall_e).
  - id_ex_pipe_reg instantiates it once for the packed control bundle and once for the packed data bundle.
  - The same sub-module serves if_id and ex_mem later.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all *_d inputs non-zero (rd1_d=64'hDEAD_BEEF) -> every output is 0. Release reset -> outputs follow the inputs one cycle later.
- Pass-through: R-type SH2ADD (reg_write_d=1, alu_control_d=1001, rd_d=5, rs1_d=1, rs2_d=2, rd1_d=3, rd2_d=4) -> next cycle alu_control_e=1001, rd_e=5, rd1_e=3, valid_e=1.
- Stall: load beq-class bundle A (branch_d=1, imm_ext_d=16), then stall_e=1 for 3 cycles while the inputs change to bundle B -> outputs stay A for all 3 cycles. Deassert stall -> B appears on the next cycle.
- Flush: EX holds SW (mem_write_e=1); pulse flush_e=1 -> next cycle mem_write_e=0, reg_write_e=0, valid_e=0, rd_e=0.
- Stall+flush together with a valid JAL on *_d -> bubble in EX (jump_e=0, valid_e=0). Next cycle, with both low, the JAL loads (jump_e=1, wd3_src_e=1, result_src_e=10).
- Reset mid-stall: stall_e=1 with EX holding a valid ADDI; assert rst_n=0 for one cycle -> all outputs 0 and the stall is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Purpose : Shared encodings and bundle types for the pipeline stages.
//           Holds the ALU operation codes, the write-back source selects,
//           the immediate-format selects and the packed control bundle.
//           The ID/EX and EX/MEM registers both carry the control bundle.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package core_pkg;

  // ALU operation codes. They pass through the pipeline register untouched.
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SH1ADD = 4'b1000;
  localparam logic [3:0] ALU_SH2ADD = 4'b1001;
  localparam logic [3:0] ALU_SH3ADD = 4'b1010;
  localparam logic [3:0] ALU_ADD_UW = 4'b1011;

  // Write-back source selects
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // Immediate format selects used by the extender in ID
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Control bundle. An all-zero value is a harmless NOP (ADD, ALU result,
  // no register or memory write), which is what a bubble relies on.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       wd3_src;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic [2:0] funct3;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);

endpackage

// File: rtl/pipe_reg_en_clr.sv
// ---------------------------------------------------------------------------
// pipe_reg_en_clr
// Purpose : Generic WIDTH-bit pipeline flop with synchronous active-low
//           reset, synchronous clear and load enable. Reset beats clear,
//           clear beats enable, so a flush always wins over a stall.
// Ports   : clk      - clock, rising edge
//           rst_n    - synchronous active-low reset
//           en_i     - load d_i when high (driven as ~stall)
//           clr_i    - load zero (bubble) when high
//           d_i      - next-stage input
//           q_o      - registered output
// ---------------------------------------------------------------------------
module pipe_reg_en_clr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state selection: clear to zero, load the input, or hold.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  // State register; reset has the highest priority and is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Purpose : Decode-to-execute pipeline register. Captures the control
//           bundle, operands, PC values, immediate and register indices at
//           the end of ID and presents them to EX one cycle later.
//           flush_e inserts an all-zero bubble; stall_e holds the contents.
//           Priority: reset, then flush, then stall, then load.
// Ports   : clk, rst_n           - clock, synchronous active-low reset
//           stall_e, flush_e     - hazard-unit hold / bubble controls
//           *_d                  - decoded instruction fields from ID
//           *_e                  - registered copies presented to EX
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
  import core_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  logic              reg_write_d,
  input  logic              mem_write_d,
  input  logic              jump_d,
  input  logic              branch_d,
  input  logic              alu_src_d,
  input  logic              wd3_src_d,
  input  logic [1:0]        result_src_d,
  input  logic [3:0]        alu_control_d,
  input  logic [2:0]        funct3_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              jump_e,
  output logic              branch_e,
  output logic              alu_src_e,
  output logic              wd3_src_e,
  output logic [1:0]        result_src_e,
  output logic [3:0]        alu_control_e,
  output logic [2:0]        funct3_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e
);

  localparam int DATA_W = 5 * XLEN + 3 * REG_AW;

  ctrl_bundle_t      ctrl_d;
  ctrl_bundle_t      ctrl_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Pack the decoded fields into the two bundles carried by the flops.
  always_comb begin
    ctrl_d             = '0;
    ctrl_d.valid       = valid_d;
    ctrl_d.reg_write   = reg_write_d;
    ctrl_d.mem_write   = mem_write_d;
    ctrl_d.jump        = jump_d;
    ctrl_d.branch      = branch_d;
    ctrl_d.alu_src     = alu_src_d;
    ctrl_d.wd3_src     = wd3_src_d;
    ctrl_d.result_src  = result_src_d;
    ctrl_d.alu_control = alu_control_d;
    ctrl_d.funct3      = funct3_d;
  end

  assign data_d = {rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d, rs1_d, rs2_d, rd_d};

  pipe_reg_en_clr #(
    .WIDTH(CTRL_W)
  ) u_ctrl_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (~stall_e),
    .clr_i(flush_e),
    .d_i  (ctrl_d),
    .q_o  (ctrl_q)
  );

  // Data fields are bubbled too so a flushed slot is fully deterministic.
  pipe_reg_en_clr #(
    .WIDTH(DATA_W)
  ) u_data_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (~stall_e),
    .clr_i(flush_e),
    .d_i  (data_d),
    .q_o  (data_q)
  );

  assign valid_e       = ctrl_q.valid;
  assign reg_write_e   = ctrl_q.reg_write;
  assign mem_write_e   = ctrl_q.mem_write;
  assign jump_e        = ctrl_q.jump;
  assign branch_e      = ctrl_q.branch;
  assign alu_src_e     = ctrl_q.alu_src;
  assign wd3_src_e     = ctrl_q.wd3_src;
  assign result_src_e  = ctrl_q.result_src;
  assign alu_control_e = ctrl_q.alu_control;
  assign funct3_e      = ctrl_q.funct3;

  assign {rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, rs1_e, rs2_e, rd_e} = data_q;

endmodule
